// File: rtl/risc_id_ex_stage.sv
// ID/EX pipeline register: forwards MEM/WB results onto the register-file
// read data, detects load-use hazards (stall + bubble), honours branch flush
// and execute back-pressure, and keeps a saturating count of hazard stalls.
module risc_id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regWrite,
  input  logic             id_memRead,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  rf_rd1,
  input  logic [XLEN-1:0]  rf_rd2,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regWrite,
  input  logic [XLEN-1:0]  mem_result,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regWrite,
  input  logic [XLEN-1:0]  wb_result,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_op1,
  output logic [XLEN-1:0]  ex_op2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rd,
  output logic             ex_regWrite,
  output logic             ex_memRead,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // x0 reads as zero; the younger MEM producer wins over WB, and WB covers
  // the case where the regfile is being written in this same cycle.
  function automatic logic [XLEN-1:0] fwdSel(
    input logic [4:0]      src,
    input logic [XLEN-1:0] rfVal,
    input logic            memRw,
    input logic [4:0]      memRd,
    input logic [XLEN-1:0] memRes,
    input logic            wbRw,
    input logic [4:0]      wbRd,
    input logic [XLEN-1:0] wbRes
  );
    if (src == 5'd0)                                  return '0;
    else if (memRw && memRd == src && memRd != 5'd0)  return memRes;
    else if (wbRw && wbRd == src && wbRd != 5'd0)     return wbRes;
    else                                              return rfVal;
  endfunction

  // Counter stops at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] val);
    return (val == CNT_MAX) ? val : val + 1'b1;
  endfunction

  logic [XLEN-1:0] op1Sel;
  logic [XLEN-1:0] op2Sel;
  logic            exHold;

  // Forwarded operands, hazard detection and decode handshake
  always_comb begin
    op1Sel = fwdSel(id_rs1, rf_rd1, mem_regWrite, mem_rd, mem_result,
                    wb_regWrite, wb_rd, wb_result);
    op2Sel = fwdSel(id_rs2, rf_rd2, mem_regWrite, mem_rd, mem_result,
                    wb_regWrite, wb_rd, wb_result);
    hazard_stall = id_valid && ex_valid && ex_memRead && ex_regWrite &&
                   (ex_rd != 5'd0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
    exHold   = ex_valid && !ex_ready;
    id_ready = !hazard_stall && (!ex_valid || ex_ready);
  end

  // ---- ID -> EX register boundary ----
  // Stage register: flush > back-pressure hold > bubble > capture > drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_op1      <= '0;
      ex_op2      <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_regWrite <= 1'b0;
      ex_memRead  <= 1'b0;
    end else if (flush) begin
      ex_valid    <= 1'b0;
      ex_regWrite <= 1'b0;
      ex_memRead  <= 1'b0;
    end else if (exHold) begin
      ex_valid    <= ex_valid;
    end else if (hazard_stall) begin
      ex_valid    <= 1'b0;
      ex_regWrite <= 1'b0;
      ex_memRead  <= 1'b0;
    end else if (id_valid && id_ready) begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_op1      <= op1Sel;
      ex_op2      <= op2Sel;
      ex_imm      <= id_imm;
      ex_rd       <= id_rd;
      ex_regWrite <= id_regWrite;
      ex_memRead  <= id_memRead;
    end else begin
      ex_valid    <= 1'b0;
      ex_regWrite <= 1'b0;
      ex_memRead  <= 1'b0;
    end
  end

  // Debug counter of load-use stall cycles not cancelled by a flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (hazard_stall && !flush) begin
      stall_count <= satInc(stall_count);
    end
  end

endmodule

// File: tb/tb_risc_id_ex_stage.sv
// Directed bench for risc_id_ex_stage with a queue scoreboard: stimulus pushes
// the expected EX-stage packet, a negedge monitor pops one per EX handshake.
module tb_risc_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_ready;
  logic [XLEN-1:0] id_pc, id_imm, rf_rd1, rf_rd2, mem_result, wb_result;
  logic [4:0] id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic id_regWrite, id_memRead, mem_regWrite, wb_regWrite, flush, ex_ready;
  logic ex_valid, ex_regWrite, ex_memRead, hazard_stall;
  logic [XLEN-1:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0] ex_rd;
  logic [CNT_W-1:0] stall_count;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  exp_t monExp;
  exp_t monAct;

  risc_id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_imm(id_imm),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .mem_rd(mem_rd), .mem_regWrite(mem_regWrite), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_regWrite(wb_regWrite), .wb_result(wb_result),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .hazard_stall(hazard_stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setId(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic [31:0] imm, input logic [31:0] r1, input logic [31:0] r2);
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_regWrite = rw; id_memRead = mr; id_imm = imm; rf_rd1 = r1; rf_rd2 = r2;
  endtask

  task automatic pushExp(input logic [31:0] pc, input logic [31:0] op1, input logic [31:0] op2,
                         input logic [31:0] imm, input logic [4:0] rd, input logic rw,
                         input logic mr);
    exp_t e;
    e.pc = pc; e.op1 = op1; e.op2 = op2; e.imm = imm; e.rd = rd; e.rw = rw; e.mr = mr;
    sb.push_back(e);
  endtask

  // Monitor: one scoreboard entry per accepted EX output
  always @(negedge clk) begin
    if (!rst && ex_valid && ex_ready && !flush) begin
      checks++;
      monAct = '{ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_regWrite, ex_memRead};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc=0x%0h, expected no output", ex_pc);
      end else begin
        monExp = sb.pop_front();
        if (monAct !== monExp) begin
          errors++;
          $display("FAIL sb_packet pc=0x%0h: got %h, expected %h", monExp.pc, monAct, monExp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_regWrite = 1'b0; id_memRead = 1'b0; id_imm = '0; rf_rd1 = '0; rf_rd2 = '0;
    mem_rd = '0; mem_regWrite = 1'b0; mem_result = '0;
    wb_rd = '0; wb_regWrite = 1'b0; wb_result = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ex_valid", {63'd0, ex_valid}, 64'd0);
    check("reset_stall_count", {62'd0, stall_count}, 64'd0);
    step();
    rst = 1'b0;

    // MEM beats WB, then WB alone, then x0 and plain regfile
    setId(32'h100, 5'd5, 5'd6, 5'd1, 1'b1, 1'b0, 32'h10, 32'h11, 32'h22);
    mem_regWrite = 1'b1; mem_rd = 5'd5; mem_result = 32'hAA;
    wb_regWrite = 1'b1; wb_rd = 5'd5; wb_result = 32'hBB;
    pushExp(32'h100, 32'hAA, 32'h22, 32'h10, 5'd1, 1'b1, 1'b0);
    step();
    mem_regWrite = 1'b0;
    setId(32'h104, 5'd5, 5'd6, 5'd2, 1'b1, 1'b0, 32'h14, 32'h11, 32'h22);
    pushExp(32'h104, 32'hBB, 32'h22, 32'h14, 5'd2, 1'b1, 1'b0);
    step();
    wb_rd = 5'd0; wb_result = 32'hFF;
    setId(32'h108, 5'd9, 5'd0, 5'd3, 1'b0, 1'b0, 32'h18, 32'h99, 32'h55);
    pushExp(32'h108, 32'h99, 32'h0, 32'h18, 5'd3, 1'b0, 1'b0);
    step();

    // Load-use: load x7, then consumer of x7 -> one bubble, then forwarded
    wb_regWrite = 1'b0;
    setId(32'h200, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h4, 32'h31, 32'h32);
    pushExp(32'h200, 32'h31, 32'h32, 32'h4, 5'd7, 1'b1, 1'b1);
    step();
    setId(32'h204, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 32'h0, 32'h70, 32'h0);
    @(negedge clk);
    check("lu_hazard_stall", {63'd0, hazard_stall}, 64'd1);
    check("lu_id_ready", {63'd0, id_ready}, 64'd0);
    step();
    mem_regWrite = 1'b1; mem_rd = 5'd7; mem_result = 32'h777;
    pushExp(32'h204, 32'h777, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0);
    @(negedge clk);
    check("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
    check("lu_bubble_ctrl", {62'd0, ex_regWrite, ex_memRead}, 64'd0);
    check("lu_hazard_clear", {63'd0, hazard_stall}, 64'd0);
    check("lu_stall_count", {62'd0, stall_count}, 64'd1);
    step();

    // Back-pressure hold for 3 cycles; inputs wiggle but outputs must not
    ex_ready = 1'b0;
    setId(32'h300, 5'd3, 5'd4, 5'd10, 1'b1, 1'b0, 32'h30, 32'h33, 32'h44);
    for (int i = 0; i < 3; i++) begin
      mem_rd = 5'd7; mem_result = 32'hDEAD0 + i; rf_rd1 = 32'h1000 + i;
      @(negedge clk);
      check("hold_pc", {32'd0, ex_pc}, 64'h204);
      check("hold_op1", {32'd0, ex_op1}, 64'h777);
      check("hold_valid_rdy", {62'd0, ex_valid, id_ready}, 64'b10);
      step();
    end
    ex_ready = 1'b1; mem_regWrite = 1'b0; rf_rd1 = 32'h33;
    pushExp(32'h300, 32'h33, 32'h44, 32'h30, 5'd10, 1'b1, 1'b0);
    step();
    setId(32'h308, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 32'h38, 32'h1, 32'h2);
    step();
    ex_ready = 1'b0;
    setId(32'h30C, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 32'h3C, 32'h1, 32'h2);
    @(negedge clk);
    check("hold2_pc", {32'd0, ex_pc}, 64'h308);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    @(negedge clk);
    check("flush_valid", {63'd0, ex_valid}, 64'd0);
    check("flush_ctrl", {62'd0, ex_regWrite, ex_memRead}, 64'd0);

    // Hazard cycle with flush does not count
    setId(32'h400, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 32'h0, 32'h1, 32'h2);
    step();
    ex_ready = 1'b0;
    setId(32'h404, 5'd9, 5'd1, 5'd13, 1'b1, 1'b0, 32'h0, 32'h1, 32'h2);
    flush = 1'b1;
    @(negedge clk);
    check("flush_hazard", {63'd0, hazard_stall}, 64'd1);
    step();
    flush = 1'b0; ex_ready = 1'b1;
    @(negedge clk);
    check("flush_no_count", {62'd0, stall_count}, 64'd1);

    // Five hazard cycles under back-pressure: saturate at 3
    setId(32'h500, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 32'h0, 32'h1, 32'h2);
    step();
    ex_ready = 1'b0;
    setId(32'h504, 5'd1, 5'd9, 5'd14, 1'b1, 1'b0, 32'h0, 32'h1, 32'h2);
    step();
    @(negedge clk);
    check("sat_count_2", {62'd0, stall_count}, 64'd2);
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    check("sat_count_3", {62'd0, stall_count}, 64'd3);

    // Asynchronous reset mid-transfer clears immediately
    flush = 1'b1;
    step();
    flush = 1'b0;
    setId(32'h600, 5'd1, 5'd0, 5'd15, 1'b1, 1'b0, 32'h0, 32'h5A, 32'h0);
    step();
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {63'd0, ex_valid}, 64'd0);
    check("arst_op1", {32'd0, ex_op1}, 64'd0);
    check("arst_count", {62'd0, stall_count}, 64'd0);
    id_valid = 1'b0; ex_ready = 1'b1;
    step();
    rst = 1'b0;
    repeat (2) step();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
